// File: rtl/task_mem_streamer.sv
// Snapshots a packed task memory on start and streams it row-major, one instruction per valid/ready beat.
// First beat is valid 1 cycle after start; out_ready low holds the beat; abort or the last beat ends in a one-cycle done pulse.
module task_mem_streamer #(
  parameter int TASK_MEM_DEPTH = 4,
  parameter int INSN_COUNT     = 16,
  parameter int INSN_SIZE      = 16,
  localparam int W  = INSN_COUNT * INSN_SIZE,
  localparam int RW = (TASK_MEM_DEPTH > 1) ? $clog2(TASK_MEM_DEPTH) : 1,
  localparam int IW = (INSN_COUNT > 1) ? $clog2(INSN_COUNT) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [TASK_MEM_DEPTH*W-1:0] task_memory,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSN_SIZE-1:0]        out_insn,
  output logic [RW-1:0]               out_row,
  output logic [IW-1:0]               out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int NB = TASK_MEM_DEPTH * INSN_COUNT;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                          state_q;
  logic [NB-1:0][INSN_SIZE-1:0]    snap_q;
  logic [RW-1:0]                   row_q;
  logic [IW-1:0]                   idx_q;
  logic [BW-1:0]                   beat_q;
  logic                            valid_q;
  logic                            done_q;
  logic                            busy_q;

  logic idx_end;
  logic row_end;
  logic xfer;

  assign idx_end = (idx_q == IW'(INSN_COUNT - 1));
  assign row_end = (row_q == RW'(TASK_MEM_DEPTH - 1));
  assign xfer    = valid_q && out_ready;

  // beat_q tracks row*INSN_COUNT+idx so the snapshot lookup needs no multiplier
  assign out_insn  = snap_q[beat_q];
  assign out_row   = row_q;
  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign out_last  = valid_q && row_end && idx_end;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q  <= task_memory;
            row_q   <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (abort || (xfer && row_end && idx_end)) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (xfer) begin
            beat_q <= beat_q + BW'(1);
            if (idx_end) begin
              idx_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_task_mem_streamer.sv
// Directed bench for task_mem_streamer: full stream, backpressure, snapshot isolation, ignored start, abort, mid-stream reset.
module tb_task_mem_streamer;

  localparam int D  = 4;
  localparam int C  = 16;
  localparam int IS = 16;
  localparam int W  = C * IS;
  localparam int NB = D * C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [D*W-1:0]    task_memory;
  logic              out_valid;
  logic              out_ready;
  logic [IS-1:0]     out_insn;
  logic [1:0]        out_row;
  logic [3:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_chk  = 0;
  int n_fail = 0;

  task_mem_streamer #(
    .TASK_MEM_DEPTH(D),
    .INSN_COUNT    (C),
    .INSN_SIZE     (IS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .task_memory(task_memory),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_insn   (out_insn),
    .out_row    (out_row),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IS-1:0] exp_insn(input int b);
    return {8'(b / C), 8'(b % C)};
  endfunction

  function automatic logic [D*W-1:0] pattern();
    logic [D*W-1:0] m;
    m = '0;
    for (int b = 0; b < NB; b++) m[b*IS +: IS] = exp_insn(b);
    return m;
  endfunction

  // Called at a negedge; pulses start and checks every beat against the {row,idx} pattern.
  task automatic run_stream(input bit rand_rdy, input bit rewrite, input bit spam);
    int beats = 0;
    int cyc   = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (beats < NB && cyc < 2000) begin
      if (rewrite && cyc == 3) task_memory = '1;
      if (spam) start = (cyc % 5 == 1);
      check("valid", out_valid, 1);
      check("done_mid", done, 0);
      check("busy_mid", busy, 1);
      check("row", out_row, beats / C);
      check("idx", out_idx, beats % C);
      check("insn", out_insn, exp_insn(beats));
      check("last", out_last, (beats == NB - 1) ? 1 : 0);
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("beat_count", beats, NB);
    check("fin_done", done, 1);
    check("fin_valid", out_valid, 0);
    check("fin_busy", busy, 1);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    if (spam) begin
      repeat (3) begin
        @(negedge clk);
        check("no_restart", out_valid, 0);
      end
    end
  endtask

  // Transfers n beats with ready high and leaves the bench at the negedge presenting beat n.
  task automatic advance(input int n);
    int beats = 0;
    int cyc   = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    while (beats < n && cyc < 500) begin
      if (out_valid) beats++;
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("adv_count", beats, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    out_ready   = 1'b0;
    task_memory = pattern();
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", out_last, 0);
    check("rst_row", out_row, 0);
    check("rst_idx", out_idx, 0);
    check("rst_insn", out_insn, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_stream(1'b0, 1'b0, 1'b0);
    run_stream(1'b1, 1'b0, 1'b0);
    run_stream(1'b1, 1'b1, 1'b0);
    task_memory = pattern();
    run_stream(1'b0, 1'b0, 1'b1);

    // Abort on beat 10 while stalled
    advance(10);
    check("ab_idx", out_idx, 10);
    check("ab_valid", out_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_valid_next", out_valid, 0);
    check("ab_done", done, 1);
    check("ab_busy", busy, 1);
    @(negedge clk);
    check("ab_done_once", done, 0);
    check("ab_idle", busy, 0);
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ab_no_beat", out_valid, 0);
      check("ab_no_done", done, 0);
    end
    abort = 1'b0;

    // Asynchronous reset at beat 20, then restart on the first edge after release
    advance(20);
    check("rs_row", out_row, 1);
    check("rs_idx", out_idx, 4);
    rst_n = 1'b0;
    #1;
    check("rs_valid", out_valid, 0);
    check("rs_busy", busy, 0);
    check("rs_done", done, 0);
    check("rs_last", out_last, 0);
    check("rs_row0", out_row, 0);
    check("rs_idx0", out_idx, 0);
    check("rs_insn", out_insn, 0);
    repeat (2) begin
      @(negedge clk);
      check("rs_no_done", done, 0);
    end
    rst_n = 1'b1;
    run_stream(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
